// File: rtl/rob_alloc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rob_alloc_ctrl
//  Brief    : Reorder-buffer dispatch-side allocation controller. Grants one
//             ROB row per dispatch group, tracks head/tail/occupancy and the
//             in-flight branch count, and sweeps every row invalid after
//             reset or flush before reopening dispatch.
//  Options  : define ROB_ALLOC_PERF_EN to add saturating stall counters.
//  Revision : 1.0 - initial release
// ============================================================================
module rob_alloc_ctrl #(
  parameter int DISPATCH_WIDTH = 2,
  parameter int ROB_ADDR_WIDTH = 4,
  parameter int MAX_BRANCH     = 8,
  localparam int DISPATCH_ADDR_WIDTH = (DISPATCH_WIDTH > 1) ? $clog2(DISPATCH_WIDTH) : 1,
  localparam int CBN_W               = $clog2(DISPATCH_WIDTH + 1)
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [DISPATCH_WIDTH-1:0]                     disp_en_i,
  input  logic [DISPATCH_WIDTH-1:0]                     disp_is_branch_i,
  output logic                                          full_o,
  output logic                                          alloc_valid_o,
  output logic [DISPATCH_WIDTH*ROB_ADDR_WIDTH-1:0]      rob_addr_o,
  output logic [DISPATCH_WIDTH*DISPATCH_ADDR_WIDTH-1:0] bank_addr_o,
  input  logic                                          commit_en_i,
  input  logic [CBN_W-1:0]                              commit_branch_num_i,
  input  logic                                          flush_i,
  output logic                                          clr_en_o,
  output logic [ROB_ADDR_WIDTH-1:0]                     clr_row_o,
`ifdef ROB_ALLOC_PERF_EN
  output logic [31:0]                                   stall_full_cnt_o,
  output logic [31:0]                                   stall_br_cnt_o,
`endif
  output logic                                          err_o
);

  localparam int ROB_ROWS = 2 ** ROB_ADDR_WIDTH;
  localparam int CNT_W    = ROB_ADDR_WIDTH + 1;
  localparam int BR_W     = $clog2(MAX_BRANCH + 1);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                    state_q;
  logic [ROB_ADDR_WIDTH-1:0] head_q, tail_q, sweep_q;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [BR_W-1:0]           br_cnt_q, br_cnt_d;
  logic                      err_q;

  logic            run, cnt_full, br_full, accept;
  logic            commit_bad, commit_ok, err_set;
  logic [BR_W-1:0] br_add, br_sub, cbn_ext;

  // Occupancy, branch-limit and acceptance decode (full uses registered state only)
  always_comb begin
    run        = (state_q == ST_RUN);
    cnt_full   = (count_q == CNT_W'(ROB_ROWS));
    br_full    = (br_cnt_q > BR_W'(MAX_BRANCH - DISPATCH_WIDTH));
    full_o     = ~run | cnt_full | br_full;
    accept     = run & ~full_o & ~flush_i & (|disp_en_i);
    cbn_ext    = BR_W'(commit_branch_num_i);
    commit_bad = commit_en_i & ((count_q == '0) | (cbn_ext > br_cnt_q));
    // Flush wins over commit, so a commit in the flush cycle is neither applied nor flagged
    commit_ok  = run & ~flush_i & commit_en_i & ~commit_bad;
    err_set    = run & ~flush_i & commit_bad;
    br_add     = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      br_add = br_add + BR_W'(disp_en_i[i] & disp_is_branch_i[i]);
    end
    br_sub     = commit_ok ? cbn_ext : '0;
    count_d    = count_q + CNT_W'(accept) - CNT_W'(commit_ok);
    br_cnt_d   = br_cnt_q + (accept ? br_add : '0) - br_sub;
  end

  // Control FSM: invalidation sweep in INIT, allocate/retire bookkeeping in RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_INIT;
      head_q   <= '0;
      tail_q   <= '0;
      sweep_q  <= '0;
      count_q  <= '0;
      br_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= err_q | err_set;
      if (flush_i) begin
        state_q  <= ST_INIT;
        head_q   <= '0;
        tail_q   <= '0;
        sweep_q  <= '0;
        count_q  <= '0;
        br_cnt_q <= '0;
      end else if (state_q == ST_INIT) begin
        sweep_q <= sweep_q + ROB_ADDR_WIDTH'(1);
        if (sweep_q == ROB_ADDR_WIDTH'(ROB_ROWS - 1)) begin
          state_q <= ST_RUN;
        end
      end else begin
        if (accept)    tail_q <= tail_q + ROB_ADDR_WIDTH'(1);
        if (commit_ok) head_q <= head_q + ROB_ADDR_WIDTH'(1);
        count_q  <= count_d;
        br_cnt_q <= br_cnt_d;
      end
    end
  end

  assign alloc_valid_o = accept;
  assign clr_en_o      = ~run;
  assign clr_row_o     = sweep_q;
  assign err_o         = err_q;

  // Every lane writes the tail row; lane i always targets bank i
  for (genvar i = 0; i < DISPATCH_WIDTH; i++) begin : g_lane
    assign rob_addr_o[i*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH]           = tail_q;
    assign bank_addr_o[i*DISPATCH_ADDR_WIDTH +: DISPATCH_ADDR_WIDTH] = DISPATCH_ADDR_WIDTH'(i);
  end

`ifdef ROB_ALLOC_PERF_EN
  logic [31:0] stall_full_q, stall_br_q;

  // Saturating stall counters; survive flush, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_full_q <= '0;
      stall_br_q   <= '0;
    end else begin
      if (run && (|disp_en_i) && cnt_full && (stall_full_q != '1)) begin
        stall_full_q <= stall_full_q + 32'd1;
      end
      if (run && (|disp_en_i) && br_full && !cnt_full && (stall_br_q != '1)) begin
        stall_br_q <= stall_br_q + 32'd1;
      end
    end
  end

  assign stall_full_cnt_o = stall_full_q;
  assign stall_br_cnt_o   = stall_br_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rob_alloc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rob_alloc_ctrl
//  Brief    : Directed self-checking bench for rob_alloc_ctrl with 2 lanes,
//             4 ROB rows and a branch limit of 4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rob_alloc_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] disp_en;
  logic [1:0] disp_is_branch;
  logic       full;
  logic       alloc_valid;
  logic [3:0] rob_addr;
  logic [1:0] bank_addr;
  logic       commit_en;
  logic [1:0] commit_branch_num;
  logic       flush;
  logic       clr_en;
  logic [1:0] clr_row;
  logic       err;
`ifdef ROB_ALLOC_PERF_EN
  logic [31:0] stall_full_cnt;
  logic [31:0] stall_br_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  rob_alloc_ctrl #(
    .DISPATCH_WIDTH (2),
    .ROB_ADDR_WIDTH (2),
    .MAX_BRANCH     (4)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .disp_en_i           (disp_en),
    .disp_is_branch_i    (disp_is_branch),
    .full_o              (full),
    .alloc_valid_o       (alloc_valid),
    .rob_addr_o          (rob_addr),
    .bank_addr_o         (bank_addr),
    .commit_en_i         (commit_en),
    .commit_branch_num_i (commit_branch_num),
    .flush_i             (flush),
    .clr_en_o            (clr_en),
    .clr_row_o           (clr_row),
`ifdef ROB_ALLOC_PERF_EN
    .stall_full_cnt_o    (stall_full_cnt),
    .stall_br_cnt_o      (stall_br_cnt),
`endif
    .err_o               (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    #1;
    n_checks++; if (full !== 1'b1)        $display("FAIL rst_full: got %b want 1", full);        else n_pass++;
    n_checks++; if (clr_en !== 1'b1)      $display("FAIL rst_clr_en: got %b want 1", clr_en);    else n_pass++;
    n_checks++; if (clr_row !== 2'd0)     $display("FAIL rst_clr_row: got %0d want 0", clr_row); else n_pass++;
    n_checks++; if (alloc_valid !== 1'b0) $display("FAIL rst_alloc_valid: got %b want 0", alloc_valid); else n_pass++;
    n_checks++; if (err !== 1'b0)         $display("FAIL rst_err: got %b want 0", err);          else n_pass++;
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++; if (clr_row !== 2'd0) $display("FAIL sweep_row0: got %0d want 0", clr_row); else n_pass++;
    for (int k = 1; k < 4; k++) begin
      tick();
      n_checks++; if (clr_row !== 2'(k) || clr_en !== 1'b1 || full !== 1'b1)
        $display("FAIL sweep_row%0d: got row=%0d clr_en=%b full=%b want row=%0d clr_en=1 full=1", k, clr_row, clr_en, full, k);
      else n_pass++;
    end
    tick();
    n_checks++; if (full !== 1'b0 || clr_en !== 1'b0)
      $display("FAIL run_open: got full=%b clr_en=%b want 0 0", full, clr_en); else n_pass++;
    n_checks++; if (rob_addr !== 4'h0)  $display("FAIL run_rob_addr: got %h want 0", rob_addr);   else n_pass++;
    n_checks++; if (bank_addr !== 2'b10) $display("FAIL run_bank_addr: got %b want 10", bank_addr); else n_pass++;
  endtask

  task automatic test_fill;
    logic [1:0] row;
    disp_en = 2'b11;
    disp_is_branch = 2'b00;
    for (int k = 0; k < 4; k++) begin
      row = 2'(k);
      #1;
      n_checks++; if (alloc_valid !== 1'b1 || rob_addr !== {row, row})
        $display("FAIL fill_grp%0d: got valid=%b rob=%h want valid=1 rob=%h", k, alloc_valid, rob_addr, {row, row});
      else n_pass++;
      tick();
    end
    #1;
    n_checks++; if (full !== 1'b1 || alloc_valid !== 1'b0)
      $display("FAIL fill_full: got full=%b valid=%b want 1 0", full, alloc_valid); else n_pass++;
  endtask

  task automatic test_commit_full;
    disp_en = 2'b00;
    commit_en = 1'b1;
    commit_branch_num = 2'd0;
    #1;
    n_checks++; if (full !== 1'b1) $display("FAIL commit_same_cycle_full: got %b want 1", full); else n_pass++;
    tick();
    commit_en = 1'b0;
    #1;
    n_checks++; if (full !== 1'b0) $display("FAIL commit_frees: got full=%b want 0", full); else n_pass++;
    disp_en = 2'b11;
    #1;
    n_checks++; if (alloc_valid !== 1'b1 || rob_addr !== 4'h0)
      $display("FAIL wrap_alloc: got valid=%b rob=%h want 1 0", alloc_valid, rob_addr); else n_pass++;
    tick();
    disp_en = 2'b00;
    #1;
    n_checks++; if (full !== 1'b1) $display("FAIL refull: got %b want 1", full); else n_pass++;
  endtask

  task automatic test_branch;
    logic [1:0] row;
    do_reset();
    disp_en = 2'b11;
    disp_is_branch = 2'b11;
    #1;
    n_checks++; if (alloc_valid !== 1'b1 || rob_addr !== 4'h0)
      $display("FAIL br_grp0: got valid=%b rob=%h want 1 0", alloc_valid, rob_addr); else n_pass++;
    tick();
    n_checks++; if (alloc_valid !== 1'b1 || rob_addr !== 4'h5)
      $display("FAIL br_grp1: got valid=%b rob=%h want 1 5", alloc_valid, rob_addr); else n_pass++;
    tick();
    n_checks++; if (full !== 1'b1 || alloc_valid !== 1'b0)
      $display("FAIL br_limit_full: got full=%b valid=%b want 1 0", full, alloc_valid); else n_pass++;
    disp_en = 2'b00;
    disp_is_branch = 2'b00;
    commit_en = 1'b1;
    commit_branch_num = 2'd2;
    tick();
    commit_en = 1'b0;
    commit_branch_num = 2'd0;
    #1;
    n_checks++; if (full !== 1'b0) $display("FAIL br_commit_frees: got full=%b want 0", full); else n_pass++;
    disp_en = 2'b11;
    commit_en = 1'b1;
    #1;
    n_checks++; if (alloc_valid !== 1'b1 || rob_addr !== 4'hA)
      $display("FAIL acc_commit: got valid=%b rob=%h want 1 a", alloc_valid, rob_addr); else n_pass++;
    tick();
    commit_en = 1'b0;
    // count should still be 1: three more groups fit, then full
    for (int k = 0; k < 3; k++) begin
      row = 2'(3 + k);
      #1;
      n_checks++; if (alloc_valid !== 1'b1 || rob_addr !== {row, row})
        $display("FAIL net_fill%0d: got valid=%b rob=%h want 1 %h", k, alloc_valid, rob_addr, {row, row});
      else n_pass++;
      tick();
    end
    #1;
    n_checks++; if (full !== 1'b1) $display("FAIL net_full: got %b want 1", full); else n_pass++;
    n_checks++; if (err !== 1'b0)  $display("FAIL br_no_err: got %b want 0", err); else n_pass++;
    disp_en = 2'b00;
  endtask

  task automatic test_flush;
    do_reset();
    disp_en = 2'b11;
    repeat (3) tick();
    flush = 1'b1;
    #1;
    n_checks++; if (alloc_valid !== 1'b0) $display("FAIL flush_beats_alloc: got %b want 0", alloc_valid); else n_pass++;
    tick();
    flush = 1'b0;
    disp_en = 2'b00;
    #1;
    n_checks++; if (clr_en !== 1'b1 || clr_row !== 2'd0 || full !== 1'b1)
      $display("FAIL flush_sweep0: got clr_en=%b row=%0d full=%b want 1 0 1", clr_en, clr_row, full); else n_pass++;
    for (int k = 1; k < 3; k++) begin
      tick();
      n_checks++; if (clr_row !== 2'(k)) $display("FAIL flush_sweep%0d: got %0d want %0d", k, clr_row, k); else n_pass++;
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    n_checks++; if (clr_row !== 2'd0 || clr_en !== 1'b1)
      $display("FAIL init_flush_restart: got row=%0d clr_en=%b want 0 1", clr_row, clr_en); else n_pass++;
    for (int k = 1; k < 4; k++) begin
      tick();
      n_checks++; if (clr_row !== 2'(k) || full !== 1'b1)
        $display("FAIL resweep%0d: got row=%0d full=%b want %0d 1", k, clr_row, full, k); else n_pass++;
    end
    tick();
    n_checks++; if (full !== 1'b0 || clr_en !== 1'b0 || rob_addr !== 4'h0)
      $display("FAIL flush_reopen: got full=%b clr_en=%b rob=%h want 0 0 0", full, clr_en, rob_addr); else n_pass++;
  endtask

  task automatic test_err;
    logic [1:0] row;
    // continues from the flushed, empty state
    commit_en = 1'b1;
    commit_branch_num = 2'd0;
    tick();
    commit_en = 1'b0;
    #1;
    n_checks++; if (err !== 1'b1) $display("FAIL err_empty_commit: got %b want 1", err); else n_pass++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (4) tick();
    n_checks++; if (err !== 1'b1 || full !== 1'b0)
      $display("FAIL err_sticky_flush: got err=%b full=%b want 1 0", err, full); else n_pass++;
    disp_en = 2'b01;
    disp_is_branch = 2'b01;
    #1;
    n_checks++; if (alloc_valid !== 1'b1 || rob_addr !== 4'h0)
      $display("FAIL gap_alloc: got valid=%b rob=%h want 1 0", alloc_valid, rob_addr); else n_pass++;
    disp_en = 2'b00;
    disp_is_branch = 2'b00;
    do_reset();
    n_checks++; if (err !== 1'b0) $display("FAIL err_cleared_rst: got %b want 0", err); else n_pass++;
    disp_en = 2'b01;
    disp_is_branch = 2'b01;
    tick();
    disp_en = 2'b00;
    disp_is_branch = 2'b00;
    commit_en = 1'b1;
    commit_branch_num = 2'd2;
    tick();
    commit_en = 1'b0;
    commit_branch_num = 2'd0;
    #1;
    n_checks++; if (err !== 1'b1) $display("FAIL err_br_underflow: got %b want 1", err); else n_pass++;
    // the bad commit must not retire: count stays 1, so three more groups fill the ROB
    disp_en = 2'b11;
    for (int k = 0; k < 3; k++) begin
      row = 2'(1 + k);
      #1;
      n_checks++; if (alloc_valid !== 1'b1 || rob_addr !== {row, row})
        $display("FAIL err_hold%0d: got valid=%b rob=%h want 1 %h", k, alloc_valid, rob_addr, {row, row});
      else n_pass++;
      tick();
    end
    #1;
    n_checks++; if (full !== 1'b1 || err !== 1'b1)
      $display("FAIL err_count_kept: got full=%b err=%b want 1 1", full, err); else n_pass++;
    disp_en = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0;
    disp_en = 2'b00;
    disp_is_branch = 2'b00;
    commit_en = 1'b0;
    commit_branch_num = 2'd0;
    flush = 1'b0;
    test_reset();
    test_fill();
    test_commit_full();
    test_branch();
    test_flush();
    test_err();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rob_alloc_ctrl.md
Name: rob_alloc_ctrl

Overview:
- Allocation controller for the reorder buffer's dispatch side.
- Each cycle it grants one ROB row to the rename/dispatch group, returning a per-lane rob_addr and bank_addr (lane i writes bank i of row tail).
- Tracks head/tail/occupancy and in-flight branch count, and drives full.
- After reset or flush, it sequences an invalidation sweep of every ROB row before reopening dispatch.

Parameters:
- DISPATCH_WIDTH, 2, lanes per group (= ROB banks); DISPATCH_ADDR_WIDTH = max(1,$clog2(DISPATCH_WIDTH)).
- ROB_ADDR_WIDTH, 4, row index width; ROB_ROWS = 2**ROB_ADDR_WIDTH.
- MAX_BRANCH, 8, max in-flight branch instructions (must be >= DISPATCH_WIDTH).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- disp_en  in  DISPATCH_WIDTH  lane i valid
- disp_is_branch  in  DISPATCH_WIDTH  lane i is branch (ignored when disp_en[i]=0)
- full  out  1  dispatch must not present a group
- alloc_valid  out  1  group accepted this cycle (ROB row write enable)
- rob_addr  out  DISPATCH_WIDTH*ROB_ADDR_WIDTH  per-lane row (all lanes = tail)
- bank_addr  out  DISPATCH_WIDTH*DISPATCH_ADDR_WIDTH  per-lane bank, lane i = i
- commit_en  in  1  retire head row
- commit_branch_num  in  $clog2(DISPATCH_WIDTH+1)  branches retired with head row
- flush  in  1  pipeline flush pulse
- clr_en  out  1  invalidate row clr_row this cycle
- clr_row  out  ROB_ADDR_WIDTH  row being invalidated
- err  out  1  sticky protocol error

Behaviour:
- Single clock domain; rst_n asserts asynchronously, deasserts synchronously to clk.
- State: head, tail (ROB_ADDR_WIDTH, natural wrap), count (ROB_ADDR_WIDTH+1), br_cnt ($clog2(MAX_BRANCH+1)), sweep (ROB_ADDR_WIDTH), FSM {INIT, RUN}.
- Reset values: FSM=INIT, all counters 0, err=0.
- Output values during reset: full=1, clr_en=1, clr_row=0, alloc_valid=0.
- INIT:
  - clr_en=1, clr_row=sweep, sweep increments each cycle.
  - When sweep==ROB_ROWS-1, go to RUN next cycle.
  - Duration is exactly ROB_ROWS cycles; full=1 throughout.
  - commit_en is ignored.
- RUN:
  - clr_en=0.
  - full is registered-state only (no input paths): full = (count==ROB_ROWS) | (br_cnt > MAX_BRANCH-DISPATCH_WIDTH).
- Accept:
  - Combinational: accept = RUN & ~full & ~flush & |disp_en.
  - alloc_valid = accept.
  - rob_addr lanes = tail and bank_addr lane i = i, valid whenever FSM=RUN regardless of accept.
  - On accept: tail+1, count+1, br_cnt += popcount(disp_en & disp_is_branch).
  - Gaps are allowed (disp_en=01 still consumes a whole row).
- Commit:
  - In RUN with commit_en & count>0: head+1, count-1, br_cnt -= commit_branch_num.
  - commit_en with count==0, or commit_branch_num>br_cnt: sets err, and state is unchanged.
- Simultaneous accept and commit: count and br_cnt update by the net amount. full can only drop on the cycle after the commit.
- full at count==ROB_ROWS: commit frees one row; full deasserts next cycle.
- Flush (any state):
  - Next cycle: head=tail=count=br_cnt=sweep=0, FSM=INIT, full=1 for ROB_ROWS cycles.
  - Flush beats a same-cycle dispatch or commit: alloc_valid=0, and the commit is dropped.
  - Flush during INIT restarts the sweep from 0.
- Reset mid-operation behaves as flush, except err is also cleared.
- err is cleared only by rst_n.

Optional Feature:
- Macro ROB_ALLOC_PERF_EN.
- Defined:
  - Adds outputs stall_full_cnt[31:0] and stall_br_cnt[31:0], reset to 0.
  - stall_full_cnt increments each RUN cycle with |disp_en & count==ROB_ROWS.
  - stall_br_cnt increments each RUN cycle with |disp_en & branch-limit full & count<ROB_ROWS.
  - Both saturate at all-ones and are cleared by reset only (not flush).
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
All scenarios use DISPATCH_WIDTH=2, ROB_ADDR_WIDTH=2 (4 rows), MAX_BRANCH=4.
- Reset release -> full=1, clr_en=1, clr_row 0,1,2,3 on consecutive cycles; 5th cycle full=0, clr_en=0, rob_addr={0,0}, bank_addr={1,0}.
- Dispatch disp_en=11 with no branches for 4 cycles -> alloc_valid=1 with rob_addr 0,1,2,3; full=1 the cycle after the 4th; a 5th group is held, alloc_valid=0.
- While full, commit_en=1 -> next cycle full=0, head=1; following group gets rob_addr=0 (wrap).
- Groups disp_en=11, disp_is_branch=11 twice -> br_cnt=4 and full=1 with count=2; commit with commit_branch_num=2 -> br_cnt=2, full=0 next cycle; simultaneous accept+commit keeps count unchanged.
- flush asserted together with disp_en=11 at count=3 -> alloc_valid=0; next 4 cycles clr_en sweep 0..3 with full=1; then count=0, rob_addr={0,0}.
- commit_en with count==0, or commit_branch_num=2 with br_cnt=1 -> err=1 and stays 1 until rst_n; head/count unchanged.
